// File: rtl/mem_pkg.sv
// Shared types, opcode/exception codes and helpers for the MEM-stage controller.
// Opcode values mirror the ALU opcode table used by the EX stage.
package mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_DONE,
        S_DRAIN
    } mem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [5:0] ALU_ADD = 6'h01;
    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h23;
    localparam logic [5:0] ALU_LBU = 6'h24;
    localparam logic [5:0] ALU_LHU = 6'h25;
    localparam logic [5:0] ALU_SB  = 6'h28;
    localparam logic [5:0] ALU_SH  = 6'h29;
    localparam logic [5:0] ALU_SW  = 6'h2b;

    localparam logic [3:0] EXP_NONE    = 4'h0;
    localparam logic [3:0] EXP_ADDRERR = 4'h4;

    function automatic logic is_load(input logic [5:0] op);
        return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
               (op == ALU_LBU) || (op == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobes/replicated data on the way out,
// load byte/half selection and sign/zero extension on the way back.
module mem_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]          op,
    input  logic [1:0]          addr_lo,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata,
    output logic [1:0]          size,
    output logic [DATA_W-1:0]   load_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wstrb    = '0;
        wdata    = store_data;
        size     = SIZE_WORD;
        load_ext = rdata;
        case (op)
            ALU_SB: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            ALU_SH: begin
                size  = SIZE_HALF;
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            ALU_SW: begin
                wstrb = 4'b1111;
            end
            ALU_LB: begin
                size     = SIZE_BYTE;
                load_ext = {{24{rd_byte[7]}}, rd_byte};
            end
            ALU_LBU: begin
                size     = SIZE_BYTE;
                load_ext = {24'd0, rd_byte};
            end
            ALU_LH: begin
                size     = SIZE_HALF;
                load_ext = {{16{rd_half[15]}}, rd_half};
            end
            ALU_LHU: begin
                size     = SIZE_HALF;
                load_ext = {16'd0, rd_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues one cache access per memory op, stalls the
// pipeline until the response returns, and presents the writeback result.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [5:0]          op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [3:0]          exception_in,
    input  logic                flush,
    input  logic                advance,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic                stall,
    output logic [DATA_W-1:0]   result_out,
    output logic                result_valid
);

    mem_state_t          state;
    logic [5:0]          op_q;
    logic [DATA_W-1:0]   alu_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [1:0]          size_q;
    logic                wr_q;
    logic                req_q;
    logic [DATA_W-1:0]   load_q;

    logic                start;
    logic [5:0]          al_op;
    logic [1:0]          al_addr;
    logic [DATA_W/8-1:0] al_wstrb;
    logic [DATA_W-1:0]   al_wdata;
    logic [1:0]          al_size;
    logic [DATA_W-1:0]   al_load;

    assign start = valid_in & is_mem_op(op) & (exception_in == EXP_NONE) & ~flush;

    // Live inputs feed the aligner while latching; latched op/addr afterwards.
    assign al_op   = (state == S_IDLE) ? op : op_q;
    assign al_addr = (state == S_IDLE) ? alu_result[1:0] : alu_q[1:0];

    mem_align #(.DATA_W(DATA_W)) u_align (
        .op        (al_op),
        .addr_lo   (al_addr),
        .store_data(store_data),
        .rdata     (data_rdata),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .size      (al_size),
        .load_ext  (al_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            alu_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            req_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        alu_q   <= alu_result;
                        wdata_q <= al_wdata;
                        wstrb_q <= al_wstrb;
                        size_q  <= al_size;
                        wr_q    <= is_store(op);
                        req_q   <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        req_q <= 1'b0;
                        // An accepted request still owes a response unless it came back already.
                        state <= (data_addr_ok && !data_data_ok) ? S_DRAIN : S_IDLE;
                    end else if (data_addr_ok) begin
                        req_q <= 1'b0;
                        if (data_data_ok) begin
                            load_q <= al_load;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_WAIT_DATA;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (flush) begin
                        state <= data_data_ok ? S_IDLE : S_DRAIN;
                    end else if (data_data_ok) begin
                        load_q <= al_load;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || advance) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (data_data_ok) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = alu_q[ADDR_W-1:0];
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;

    assign stall = ((state == S_IDLE) & start) | (state == S_REQ) |
                   (state == S_WAIT_DATA) | (state == S_DRAIN);

    always_comb begin
        result_out   = '0;
        result_valid = 1'b0;
        if (state == S_DONE) begin
            result_valid = 1'b1;
            result_out   = is_load(op_q) ? load_q : alu_q;
        end else if (state == S_IDLE && valid_in &&
                     (!is_mem_op(op) || exception_in != EXP_NONE)) begin
            result_valid = 1'b1;
            result_out   = alu_result;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, stalls, flushes, bypass.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [5:0]  op;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [3:0]  exception_in;
    logic        flush;
    logic        advance;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall;
    logic [31:0] result_out;
    logic        result_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .op(op),
        .alu_result(alu_result), .store_data(store_data),
        .exception_in(exception_in), .flush(flush), .advance(advance),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .stall(stall), .result_out(result_out),
        .result_valid(result_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] sd);
        valid_in     = 1'b1;
        op           = o;
        alu_result   = a;
        store_data   = sd;
        exception_in = EXP_NONE;
    endtask

    // Load with addr_ok one cycle after request and data_ok one cycle later; leaves DUT in DONE.
    task automatic do_load(input logic [5:0] o, input logic [31:0] a, input logic [31:0] rd);
        issue(o, a, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_rdata   = rd;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        valid_in     = 1'b0;
    endtask

    task automatic retire();
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    initial begin
        rst = 1'b0; valid_in = 0; op = '0; alu_result = '0; store_data = '0;
        exception_in = '0; flush = 0; advance = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
        #12;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_wstrb", 32'(data_wstrb), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // SW with 1-cycle addr_ok, then data_ok
        issue(ALU_SW, 32'h1000_0004, 32'hDEAD_BEEF);
        #1 chk("sw_stall_idle", 32'(stall), 32'd1);
        tick();
        chk("sw_req", 32'(data_req), 32'd1);
        chk("sw_wr", 32'(data_wr), 32'd1);
        chk("sw_wstrb", 32'(data_wstrb), 32'hF);
        chk("sw_wdata", data_wdata, 32'hDEAD_BEEF);
        chk("sw_addr", data_addr, 32'h1000_0004);
        chk("sw_size", 32'(data_size), 32'd2);
        chk("sw_stall_req", 32'(stall), 32'd1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("sw_req_drop", 32'(data_req), 32'd0);
        chk("sw_stall_wait", 32'(stall), 32'd1);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        valid_in = 1'b0;
        chk("sw_done_valid", 32'(result_valid), 32'd1);
        chk("sw_done_stall", 32'(stall), 32'd0);
        chk("sw_done_result", result_out, 32'h1000_0004);
        tick();
        chk("sw_hold_result", result_out, 32'h1000_0004);
        retire();
        chk("sw_retired", 32'(result_valid), 32'd0);

        // Loads with extension
        do_load(ALU_LB, 32'h2000_0003, 32'h8012_3456);
        chk("lb_result", result_out, 32'hFFFF_FF80);
        chk("lb_valid", 32'(result_valid), 32'd1);
        retire();
        do_load(ALU_LBU, 32'h2000_0003, 32'h8012_3456);
        chk("lbu_result", result_out, 32'h0000_0080);
        retire();
        do_load(ALU_LH, 32'h2000_0002, 32'h8001_7FFF);
        chk("lh_result", result_out, 32'hFFFF_8001);
        retire();
        do_load(ALU_LW, 32'h2000_0000, 32'hCAFE_F00D);
        chk("lw_result", result_out, 32'hCAFE_F00D);
        chk("lw_wstrb", 32'(data_wstrb), 32'h0);
        retire();

        // SH upper half, then SB lane 1
        issue(ALU_SH, 32'h3000_0002, 32'h0000_1234);
        tick();
        chk("sh_wstrb", 32'(data_wstrb), 32'hC);
        chk("sh_wdata", data_wdata, 32'h1234_1234);
        chk("sh_size", 32'(data_size), 32'd1);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; valid_in = 1'b0;
        chk("sh_same_cycle_done", 32'(result_valid), 32'd1);
        retire();
        issue(ALU_SB, 32'h3000_0001, 32'h0000_00AB);
        tick();
        chk("sb_wstrb", 32'(data_wstrb), 32'h2);
        chk("sb_wdata", data_wdata, 32'hABAB_ABAB);
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; valid_in = 1'b0;
        retire();

        // LHU with addr_ok and data_ok together in REQ
        issue(ALU_LHU, 32'h4000_0000, 32'h0);
        tick();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_ABCD;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; valid_in = 1'b0;
        chk("lhu_same_cycle", result_out, 32'h0000_ABCD);
        retire();

        // addr_ok withheld: request must stay stable
        issue(ALU_SB, 32'h5000_0003, 32'h0000_0077);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", 32'(data_req), 32'd1);
            chk("hold_addr", data_addr, 32'h5000_0003);
            chk("hold_wstrb", 32'(data_wstrb), 32'h8);
            chk("hold_stall", 32'(stall), 32'd1);
            alu_result = 32'h9999_9990 + 32'(i);
            tick();
        end
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; valid_in = 1'b0;
        retire();

        // flush in WAIT_DATA, response 3 cycles later
        issue(ALU_LW, 32'h6000_0000, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush = 1'b1; valid_in = 1'b0;
        tick();
        flush = 1'b0;
        chk("drain_stall0", 32'(stall), 32'd1);
        chk("drain_rvalid0", 32'(result_valid), 32'd0);
        tick();
        chk("drain_stall1", 32'(stall), 32'd1);
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        tick();
        data_data_ok = 1'b0;
        chk("drain_done_stall", 32'(stall), 32'd0);
        chk("drain_done_rvalid", 32'(result_valid), 32'd0);

        // flush in REQ drops the request
        issue(ALU_LW, 32'h7000_0000, 32'h0);
        tick();
        chk("freq_req", 32'(data_req), 32'd1);
        flush = 1'b1; valid_in = 1'b0;
        tick();
        flush = 1'b0;
        chk("freq_drop", 32'(data_req), 32'd0);
        chk("freq_stall", 32'(stall), 32'd0);

        // faulted load and non-memory op bypass
        issue(ALU_LW, 32'h8000_0001, 32'h0);
        exception_in = EXP_ADDRERR;
        #1;
        chk("exc_stall", 32'(stall), 32'd0);
        chk("exc_rvalid", 32'(result_valid), 32'd1);
        chk("exc_result", result_out, 32'h8000_0001);
        tick();
        chk("exc_noreq", 32'(data_req), 32'd0);
        issue(ALU_ADD, 32'h0000_0042, 32'h0);
        #1;
        chk("add_result", result_out, 32'h0000_0042);
        chk("add_rvalid", 32'(result_valid), 32'd1);
        chk("add_stall", 32'(stall), 32'd0);
        tick();
        valid_in = 1'b0;

        // reset mid-transaction, stale response ignored
        issue(ALU_LW, 32'h9000_0000, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_req", 32'(data_req), 32'd0);
        valid_in = 1'b0;
        tick();
        rst = 1'b1;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("stale_rvalid", 32'(result_valid), 32'd0);
        chk("stale_stall", 32'(stall), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory stage controller directly downstream of the EX-stage ALU.
- Consumes the ALU op, effective address (ALU result) and store data.
- Drives the data-cache request/response handshake, generates store byte strobes, and aligns/extends load data.
- Returns a stall to the pipeline and the final MEM result: load data for loads, ALU result passed through otherwise.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, byte lanes = DATA_W/8

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  MEM-stage instruction valid
- op  in  6  ALU opcode; ALU_LB/LBU/LH/LHU/LW/SB/SH/SW are the memory ops, per aluop.vh
- alu_result  in  32  effective address, or ALU result for non-memory ops
- store_data  in  32  rt value for stores
- exception_in  in  4  exception code from EX; non-zero means the instruction is already faulted
- flush  in  1  synchronous pipeline flush (exception/ERET commit)
- advance  in  1  pipeline consumes the MEM result this cycle
- data_req  out  1  cache request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  byte address; unaligned low bits are kept
- data_wstrb  out  4  store byte enables
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  raw read word
- stall  out  1  hold upstream stages
- result_out  out  32  extended load data, or alu_result passthrough
- result_valid  out  1  result_out valid for writeback

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all latched fields cleared.
  - data_req=0, stall=0, result_valid=0, result_out=0, data_wstrb=0.
- start = valid_in & is_mem_op(op) & (exception_in==0) & ~flush, sampled in IDLE.
- If valid_in and the instruction is not a memory op or exception_in!=0:
  - No request is issued; result_out=alu_result and result_valid=valid_in, combinationally.
  - stall=0.
- FSM states: IDLE, REQ, WAIT_DATA, DONE, DRAIN.
  - IDLE: on start, latch op/addr/wdata/strb/size and go to REQ.
  - REQ: data_req=1. All request outputs stay stable until data_addr_ok. On addr_ok go to WAIT_DATA.
  - WAIT_DATA: on data_data_ok, capture the extended load data (stores capture nothing) and go to DONE.
  - DONE: result_valid=1, stall=0. On advance go to IDLE, otherwise hold the result.
  - DRAIN: wait for data_data_ok, discard it, then go to IDLE.
- stall = (IDLE & start) | REQ | WAIT_DATA | DRAIN.
- Minimum latency with addr_ok and data_ok each arriving one cycle after their trigger: 3 cycles IDLE to DONE.
- addr_ok and data_ok in the same cycle while in REQ: go straight to DONE and capture data.
- Flush:
  - In REQ before addr_ok: drop the request and go to IDLE.
  - In REQ with addr_ok in the same cycle, or in WAIT_DATA: go to DRAIN (the accepted request must complete).
  - In DONE: go to IDLE with no result.
  - In DRAIN, data_ok: go to IDLE.
- Stores:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: wstrb=addr[1]?4'b1100:4'b0011, wdata={2{sd[15:0]}}.
  - SW: wstrb=4'b1111, wdata=sd.
  - Loads drive wstrb=0.
- Loads:
  - Byte selected by addr[1:0], halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Alignment is the ALU's job; faulted accesses arrive with exception_in!=0 and never reach the cache.
- Reset mid-transaction returns to IDLE immediately. Any cache response that arrives later is ignored in IDLE.

Decomposition:
- Shared package mem_pkg:
  - state enum mem_state_t
  - size constants SIZE_BYTE/HALF/WORD
  - function is_mem_op(op)
- Combinational sub-module mem_align: op + addr[1:0] + store_data + rdata -> wstrb, wdata, size, load_ext.

Test Plan:
- SW addr=0x1000_0004, sd=0xDEADBEEF, addr_ok after 1 cycle, data_ok after 2 -> data_wstrb=4'hF, data_wdata=0xDEADBEEF, data_wr=1; stall high until DONE.
- LB addr=0x...03, rdata=0x80123456 -> result_out=0xFFFFFF80; LBU same -> 0x00000080.
- LH addr=0x...02, rdata=0x8001_7FFF -> result_out=0xFFFF8001; SH addr=0x...02 sd=0x1234 -> wstrb=4'b1100, wdata=0x12341234.
- addr_ok held 0 for 5 cycles -> data_req, data_addr, data_wstrb constant, stall=1 throughout.
- flush in WAIT_DATA, data_ok 3 cycles later -> DRAIN, then IDLE, no result_valid; flush in REQ -> data_req drops next cycle.
- LW with exception_in=EXP_ADDRERR -> no data_req, stall=0, result_valid=1; ADD op -> result_out=alu_result same cycle.
